// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MEM stage and a single-outstanding
// req/ack data bus. Stalls the pipeline for the duration of an access, returns
// sign/zero-extended load data, and reports misaligned, illegal-op and timeout errors.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_rd, mem_wr, mem_op   access request and funct3 from the MEM stage
//   mem_addr, mem_wdata      byte address and right-aligned store data
//   lsu_stall                pipeline hold (combinational)
//   lsu_done, lsu_err        completion / error completion, one cycle
//   lsu_err_cause            01 misaligned, 10 illegal op, 11 bus timeout
//   ld_data                  extended load result, held until the next load
//   bus_req/we/addr/wdata/be data bus request side
//   bus_ack, bus_rdata       data bus completion side
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] ld_data,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              err_q, err_d;
    logic [1:0]        cause_q, cause_d;

    // Request decode from the live MEM-stage inputs
    logic        req_c;
    logic        illegal_c;
    logic        misal_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    assign req_c = mem_rd | mem_wr;

    always_comb begin
        // Stores win when both mem_rd and mem_wr are set.
        if (mem_wr) begin
            illegal_c = mem_op[2] | (mem_op[1:0] == 2'b11);
        end else begin
            illegal_c = (mem_op[1:0] == 2'b11) | (mem_op == 3'b110);
        end
        misal_c = ((mem_op[1:0] == 2'b01) & mem_addr[0]) |
                  ((mem_op[1:0] == 2'b10) & (mem_addr[1:0] != 2'b00));
        case (mem_op[1:0])
            2'b00: begin
                be_c    = 4'b0001 << mem_addr[1:0];
                wdata_c = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_c = {2{mem_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = mem_wdata;
            end
        endcase
    end

    // Load lane extraction using the latched op and byte offset
    logic [31:0] rshift_c;
    logic [7:0]  rbyte_c;
    logic [15:0] rhalf_c;
    logic [31:0] ld_ext_c;

    always_comb begin
        rshift_c = bus_rdata >> {off_q, 3'b000};
        rbyte_c  = rshift_c[7:0];
        rhalf_c  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_q)
            3'b000:  ld_ext_c = {{24{rbyte_c[7]}}, rbyte_c};
            3'b001:  ld_ext_c = {{16{rhalf_c[15]}}, rhalf_c};
            3'b100:  ld_ext_c = {24'd0, rbyte_c};
            3'b101:  ld_ext_c = {16'd0, rhalf_c};
            default: ld_ext_c = bus_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        ld_data_d   = ld_data_q;
        err_d       = err_q;
        cause_d     = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (illegal_c || misal_c) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        cause_d = illegal_c ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                    end else begin
                        state_d     = ST_WAIT;
                        cnt_d       = '0;
                        op_d        = mem_op;
                        off_d       = mem_addr[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wr;
                        bus_addr_d  = {mem_addr[31:2], 2'b00};
                        bus_wdata_d = wdata_c;
                        bus_be_d    = be_c;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        ld_data_d = ld_ext_c;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    cause_d   = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // The request still visible here belongs to the completed instruction.
                state_d = ST_IDLE;
                err_d   = 1'b0;
                cause_d = 2'b00;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            ld_data_q   <= '0;
            err_q       <= 1'b0;
            cause_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            ld_data_q   <= ld_data_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
        end
    end

    assign lsu_stall     = ((state_q == ST_IDLE) & req_c) | (state_q == ST_WAIT);
    assign lsu_done      = (state_q == ST_DONE);
    assign lsu_err       = err_q;
    assign lsu_err_cause = cause_q;
    assign ld_data       = ld_data_q;
    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_be        = bus_be_q;

endmodule
